pay_station: RTL and testbench

- Payment front-end placed directly upstream of the gate controller.
- Accepts coins while a car is present and accumulates credit against a fixed fee.
- Once the fee is covered, asserts pay_ok_o, which the gate controller samples together with car_i.
- Computes change, refunds on cancel, timeout or car departure, and releases pay_ok_o when the controller issues its gate-open pulse.

---
 rtl/pay_station.sv | 146 ++++++++++++++
 tb/tb_pay_station.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pay_station.sv
// Parking pay station: collects coins against a fixed fee, reports change and
// refunds, and holds pay_ok_o until the gate controller consumes the payment.
module pay_station #(
  parameter int FEE         = 15,
  parameter int TIMEOUT_CYC = 1000,
  parameter int TMR_W       = 10
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       car_i,
  input  logic       coin_valid_i,
  input  logic [1:0] coin_code_i,
  input  logic       cancel_i,
  input  logic       gate_open_i,
  output logic       pay_ok_o,
  output logic [7:0] credit_o,
  output logic       change_valid_o,
  output logic [7:0] change_o,
  output logic       coin_reject_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PAID    = 2'd2,
    REFUND  = 2'd3
  } state_t;

  localparam logic [7:0]       FEE_C    = 8'(FEE);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYC - 1);

  function automatic logic [7:0] coin_value(input logic [1:0] code);
    case (code)
      2'd0:    coin_value = 8'd1;
      2'd1:    coin_value = 8'd2;
      2'd2:    coin_value = 8'd5;
      default: coin_value = 8'd10;
    endcase
  endfunction

  // Credit never wraps: anything above 255 clamps to 255.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    sat_add = s[8] ? 8'hFF : s[7:0];
  endfunction

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [7:0]       credit_d, change_d, coin_val, sum;
  logic             pay_ok_d, change_valid_d, coin_reject_d;

  assign coin_val = coin_value(coin_code_i);
  assign sum      = sat_add(credit_o, coin_val);

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    credit_d       = credit_o;
    change_d       = change_o;
    pay_ok_d       = pay_ok_o;
    change_valid_d = 1'b0;
    coin_reject_d  = 1'b0;

    case (state_q)
      IDLE: begin
        pay_ok_d = 1'b0;
        timer_d  = '0;
        if (coin_valid_i) begin
          if (car_i) begin
            state_d  = COLLECT;
            credit_d = coin_val;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end

      COLLECT: begin
        if (!car_i || cancel_i) begin
          // Departure/cancel wins over a simultaneous coin, which goes back.
          state_d        = REFUND;
          change_d       = credit_o;
          change_valid_d = 1'b1;
          credit_d       = '0;
          timer_d        = '0;
          coin_reject_d  = coin_valid_i;
        end else if (coin_valid_i) begin
          timer_d = '0;
          if (sum >= FEE_C) begin
            state_d        = PAID;
            change_d       = sum - FEE_C;
            change_valid_d = 1'b1;
            pay_ok_d       = 1'b1;
            credit_d       = '0;
          end else begin
            credit_d = sum;
          end
        end else if (timer_q == TMO_LAST) begin
          state_d        = REFUND;
          change_d       = credit_o;
          change_valid_d = 1'b1;
          credit_d       = '0;
          timer_d        = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      PAID: begin
        // A paid ticket survives the car backing off; only the gate consumes it.
        coin_reject_d = coin_valid_i;
        if (gate_open_i) begin
          state_d  = IDLE;
          pay_ok_d = 1'b0;
        end
      end

      default: begin
        coin_reject_d = coin_valid_i;
        state_d       = IDLE;
      end
    endcase
  end

  always_ff @(negedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      credit_o       <= '0;
      change_o       <= '0;
      pay_ok_o       <= 1'b0;
      change_valid_o <= 1'b0;
      coin_reject_o  <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      credit_o       <= credit_d;
      change_o       <= change_d;
      pay_ok_o       <= pay_ok_d;
      change_valid_o <= change_valid_d;
      coin_reject_o  <= coin_reject_d;
    end
  end

endmodule

// File: tb/tb_pay_station.sv
// Bench for pay_station: directed scenarios with literal expectations plus a
// random phase, all checked every cycle against a transaction-level model.
module tb_pay_station;
  localparam int FEE = 15;
  localparam int TMO = 4;

  logic       clk_i = 1'b1;
  logic       reset_i = 1'b1;
  logic       car_i = 1'b0, coin_valid_i = 1'b0, cancel_i = 1'b0, gate_open_i = 1'b0;
  logic [1:0] coin_code_i = 2'd0;
  logic       pay_ok_o, change_valid_o, coin_reject_o;
  logic [7:0] credit_o, change_o;

  pay_station #(.FEE(FEE), .TIMEOUT_CYC(TMO), .TMR_W(3)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .car_i(car_i), .coin_valid_i(coin_valid_i),
    .coin_code_i(coin_code_i), .cancel_i(cancel_i), .gate_open_i(gate_open_i),
    .pay_ok_o(pay_ok_o), .credit_o(credit_o), .change_valid_o(change_valid_o),
    .change_o(change_o), .coin_reject_o(coin_reject_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: a ticket is either open (collecting), paid,
  // just refunded, or absent; credit and idle time are plain integers.
  bit m_open, m_paid, m_refunded;
  int m_credit, m_idle;
  int e_credit, e_change;
  bit e_pay_ok, e_cv, e_rej;

  function automatic int value_of(input logic [1:0] c);
    int tbl[4] = '{1, 2, 5, 10};
    return tbl[c];
  endfunction

  task automatic m_refund();
    m_open = 0; m_refunded = 1; e_change = m_credit; e_cv = 1; m_credit = 0;
  endtask

  always @(negedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      m_open = 0; m_paid = 0; m_refunded = 0; m_credit = 0; m_idle = 0;
      e_credit = 0; e_change = 0; e_pay_ok = 0; e_cv = 0; e_rej = 0;
    end else begin
      int s;
      e_cv = 0; e_rej = 0;
      if (m_refunded) begin
        m_refunded = 0; e_rej = coin_valid_i;
      end else if (m_paid) begin
        e_rej = coin_valid_i;
        if (gate_open_i) begin m_paid = 0; e_pay_ok = 0; end
      end else if (m_open) begin
        if (!car_i || cancel_i) begin
          m_refund(); e_rej = coin_valid_i;
        end else if (coin_valid_i) begin
          s = m_credit + value_of(coin_code_i);
          if (s > 255) s = 255;
          m_idle = 0;
          if (s >= FEE) begin
            m_open = 0; m_paid = 1; e_pay_ok = 1; e_change = s - FEE; e_cv = 1; m_credit = 0;
          end else m_credit = s;
        end else begin
          m_idle++;
          if (m_idle == TMO) m_refund();
        end
      end else if (coin_valid_i) begin
        if (car_i) begin m_open = 1; m_credit = value_of(coin_code_i); m_idle = 0; end
        else e_rej = 1;
      end
      e_credit = m_credit;
    end
  end

  always @(posedge clk_i) begin
    if (cmp_en) begin
      chk("pay_ok", pay_ok_o, e_pay_ok);
      chk("credit", credit_o, e_credit);
      chk("change_valid", change_valid_o, e_cv);
      chk("coin_reject", coin_reject_o, e_rej);
      if (e_cv) chk("change", change_o, e_change);
    end
  end

  task automatic drive(input bit car, input bit coin, input logic [1:0] code,
                       input bit cancel, input bit gate);
    car_i = car; coin_valid_i = coin; coin_code_i = code;
    cancel_i = cancel; gate_open_i = gate;
    @(posedge clk_i); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0);
  endtask

  initial begin
    @(posedge clk_i); #1;
    chk("rst_pay_ok", pay_ok_o, 0);
    chk("rst_credit", credit_o, 0);
    chk("rst_change", change_o, 0);
    chk("rst_cv", change_valid_o, 0);
    chk("rst_rej", coin_reject_o, 0);
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    cmp_en = 1'b1;

    // Exact fee: 10 then 5
    drive(1, 1, 3, 0, 0); chk("s1_credit10", credit_o, 10); chk("s1_no_pay", pay_ok_o, 0);
    drive(1, 1, 2, 0, 0); chk("s1_pay_ok", pay_ok_o, 1); chk("s1_cv", change_valid_o, 1);
    chk("s1_change0", change_o, 0); chk("s1_credit0", credit_o, 0);
    idle(1); chk("s1_cv_pulse", change_valid_o, 0); chk("s1_hold", pay_ok_o, 1);
    drive(1, 0, 0, 0, 1); chk("s1_released", pay_ok_o, 0);
    idle(1);

    // Overpay 10+10, then a rejected coin in PAID
    drive(1, 1, 3, 0, 0); drive(1, 1, 3, 0, 0);
    chk("s2_change5", change_o, 5); chk("s2_model_change", e_change, 5);
    drive(1, 1, 1, 0, 0); chk("s2_reject", coin_reject_o, 1); chk("s2_credit", credit_o, 0);
    chk("s2_hold", pay_ok_o, 1);
    drive(0, 0, 0, 1, 0); chk("s2_car_gone_still_paid", pay_ok_o, 1);
    drive(1, 0, 0, 0, 1); idle(1);

    // Cancel with simultaneous coin
    drive(1, 1, 2, 0, 0); chk("s3_credit5", credit_o, 5);
    drive(1, 1, 3, 1, 0); chk("s3_cv", change_valid_o, 1); chk("s3_change5", change_o, 5);
    chk("s3_rej", coin_reject_o, 1); chk("s3_credit0", credit_o, 0);
    idle(1); chk("s3_cv_pulse", change_valid_o, 0);

    // Timeout: refund exactly TMO cycles after the coin edge
    drive(1, 1, 0, 0, 0);
    idle(TMO - 1); chk("s4_not_yet", change_valid_o, 0);
    idle(1); chk("s4_cv", change_valid_o, 1); chk("s4_change1", change_o, 1);
    chk("s4_no_pay", pay_ok_o, 0);
    idle(1);

    // No car: coin rejected; car leaves with credit 7
    drive(0, 1, 3, 0, 0); chk("s5_rej", coin_reject_o, 1); chk("s5_credit0", credit_o, 0);
    drive(1, 1, 2, 0, 0); drive(1, 1, 1, 0, 0); chk("s5_credit7", credit_o, 7);
    drive(0, 0, 0, 0, 0); chk("s5_cv", change_valid_o, 1); chk("s5_change7", change_o, 7);
    idle(1);

    // Asynchronous reset mid-collect with credit 9
    drive(1, 1, 2, 0, 0); drive(1, 1, 1, 0, 0); drive(1, 1, 1, 0, 0);
    chk("s6_credit9", credit_o, 9);
    reset_i = 1'b1; #1;
    chk("s6_async_credit", credit_o, 0); chk("s6_async_cv", change_valid_o, 0);
    chk("s6_async_pay", pay_ok_o, 0);
    @(posedge clk_i); #1;
    chk("s6_no_refund", change_valid_o, 0);
    reset_i = 1'b0;
    drive(1, 1, 3, 0, 0); chk("s6_resume", credit_o, 10);
    idle(TMO + 1);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset_i = 1'b1; @(posedge clk_i); #1; reset_i = 1'b0;
      end
      drive($urandom_range(0, 15) != 0, $urandom_range(0, 2) == 0,
            2'($urandom_range(0, 3)), $urandom_range(0, 39) == 0,
            $urandom_range(0, 5) == 0);
    end

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
